fifo_packer: RTL and testbench
==============================

Name: fifo_packer

Overview:
Downstream consumer of the single-in/single-out fifo. It drains narrow words through the fifo's read/valid interface and packs RATIO consecutive words into one wide beat. The wide beat is presented on a valid/ready output. A partial beat can be flushed early, with per-lane keep bits. It sits between the fifo and a wide datapath or bus master.

Parameters:
WIDTH, 8, width of one fifo word.
RATIO, 4, words per output beat; must be ≥2.
TIMEOUT, 16, idle cycles before an automatic partial flush; used only with the optional feature; must be ≥1.

Ports:
clk  input  1  clock, all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
fifo_read_o  output  1  read request to the fifo (the fifo's read_i).
fifo_vld_i  input  1  word accepted this cycle (the fifo's out_vld_o; already gated by not-empty).
fifo_data_i  input  WIDTH  fifo head word; valid when fifo_vld_i=1.
fifo_empty_i  input  1  fifo empty flag.
flush_i  input  1  request to emit the partial beat.
out_vld_o  output  1  wide beat valid.
out_rdy_i  input  1  downstream ready.
out_data_o  output  WIDTH*RATIO  packed beat; lane 0 occupies the LSBs.
out_keep_o  output  RATIO  per-lane valid mask.

Behaviour:
- State machine: states FILL and HOLD. Lane counter cnt runs 0..RATIO-1, width $clog2(RATIO). The accumulator holds RATIO lanes.
- Reset: state=FILL, cnt=0, accumulator=0. out_vld_o=0, out_data_o=0, out_keep_o=0. fifo_read_o is forced 0 while reset=1.
- Read enable: fifo_read_o = ~reset & ~fifo_empty_i & (state==FILL | out_rdy_i). It is combinational on out_rdy_i.
- Word accept: a word is accepted when fifo_vld_i=1. The word is written to lane cnt, and keep[cnt] is set.
- Full beat: when a word is accepted with cnt==RATIO-1, the next cycle is HOLD, cnt=0, out_keep_o all ones.
  - Latency: the beat is valid 1 cycle after the last word is accepted.
- HOLD: out_vld_o=1. out_data_o and out_keep_o are stable until out_rdy_i=1.
  - On handshake with no word accepted: go to FILL, clear keep and data to 0.
  - Handshake and word accept in the same cycle: the new word goes into lane 0 of a fresh accumulator (keep=0001), state=FILL, cnt=1.
  - Sustained throughput is 1 word per cycle.
- Flush: flush_i=1 in FILL with at least one lane occupied (counting a word accepted in the same cycle) goes to HOLD with the partial keep mask. Unused lanes read 0.
  - flush_i is ignored in FILL with nothing occupied, and ignored in HOLD.
  - If the accepted word completes the beat, the flush is absorbed into the normal full beat.
- Reset mid-operation discards the accumulator and any held beat. Words already read from the fifo are lost.
- out_vld_o must not drop, and out_data_o must not change, while out_rdy_i=0.

Optional Feature:
FIFO_PACKER_TIMEOUT_EN.
- Defined: an idle counter of width $clog2(TIMEOUT+1) counts cycles in FILL with cnt>0 and no word accepted. It clears on accept, on entering HOLD, and on reset. Reaching TIMEOUT acts exactly as flush_i on that cycle.
- Undefined: no counter is built, and a partial beat leaves only via flush_i.

Decomposition:
- Package fifo_packer_pkg: state typedef enum {FILL, HOLD}, and a lane index width constant function.
- Sub-module fifo_packer_timer (idle counter plus terminal pulse), instantiated only under FIFO_PACKER_TIMEOUT_EN.

Test Plan (WIDTH=8, RATIO=4, TIMEOUT=16):
- Fifo preloaded with 0x11,0x22,0x33,0x44, out_rdy_i=1 → one beat 0x44332211, keep=1111, 1 cycle after the 4th accept.
- 8 words 0x01..0x08 with out_rdy_i held 1 → beats 0x04030201 then 0x08070605 back-to-back, no idle cycle between reads.
- 4 words with out_rdy_i=0 for 5 cycles → out_vld_o=1 and data stable throughout; fifo_read_o=0 while fifo is non-empty; release → single handshake.
- 2 words 0xAA,0xBB then flush_i pulse → beat 0x0000BBAA, keep=0011; flush_i with cnt=0 → no beat.
- FIFO_PACKER_TIMEOUT_EN, 1 word 0x5A then fifo empty → beat 0x0000005A keep=0001 after exactly 16 idle cycles; undefined → no beat after 100 cycles.
- reset asserted in HOLD with a 3-lane partial beat → next cycle out_vld_o=0, out_keep_o=0, a subsequent full beat is correct.

Source files
------------

// File: rtl/fifo_packer_pkg.sv
// fifo_packer_pkg: state encoding and lane-index sizing shared by the packer and its idle timer.
// Pure declarations; no latency or backpressure of its own.
package fifo_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Keeps the lane counter at least one bit wide even for degenerate ratios.
    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_packer_timer.sv
// fifo_packer_timer: counts idle FILL cycles; expire_o pulses combinationally on the TIMEOUT-th one.
// No backpressure; clear has priority over counting.
module fifo_packer_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expire_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q;
    logic [TW-1:0] idle_d;

    always_comb begin
        expire_o = count_en && (idle_q == TW'(TIMEOUT - 1));
        idle_d   = idle_q;
        if (clear || expire_o) begin
            idle_d = '0;
        end else if (count_en) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/fifo_packer.sv
// fifo_packer: packs RATIO fifo words into one wide beat; beat valid 1 cycle after the last word.
// Backpressure: beat held and fifo reads stall while out_rdy_i=0. Optional idle flush: FIFO_PACKER_TIMEOUT_EN.
module fifo_packer
    import fifo_packer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   fifo_read_o,
    input  logic                   fifo_vld_i,
    input  logic [WIDTH-1:0]       fifo_data_i,
    input  logic                   fifo_empty_i,
    input  logic                   flush_i,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [WIDTH*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]       out_keep_o
);

    localparam int CW = lane_idx_w(RATIO);

    if (RATIO < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("fifo_packer: RATIO must be >= 2 and TIMEOUT >= 1");
    end

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [WIDTH*RATIO-1:0]   data_q, data_d, acc_data;
    logic [RATIO-1:0]         keep_q, keep_d, acc_keep;
    logic                     in_fill;
    logic                     accept;
    logic                     last_lane;
    logic                     timeout_hit;

    assign in_fill     = (state_q == FILL);
    assign fifo_read_o = ~reset & ~fifo_empty_i & (in_fill | out_rdy_i);
    // A word can only land while there is room: in FILL, or as the held beat leaves.
    assign accept      = fifo_vld_i & (in_fill | out_rdy_i);
    assign last_lane   = (cnt_q == CW'(RATIO - 1));

`ifdef FIFO_PACKER_TIMEOUT_EN
    fifo_packer_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .count_en (in_fill && (cnt_q != '0) && !accept),
        .clear    (accept || !in_fill),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        acc_data = data_q;
        acc_keep = keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (accept && (cnt_q == CW'(i))) begin
                acc_data[i*WIDTH +: WIDTH] = fifo_data_i;
                acc_keep[i]                = 1'b1;
            end
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;

        case (state_q)
            FILL: begin
                data_d = acc_data;
                keep_d = acc_keep;
                // A completing word absorbs any simultaneous flush into the full beat.
                if ((accept && last_lane) || ((flush_i || timeout_hit) && (|acc_keep))) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_rdy_i) begin
                    state_d = FILL;
                    data_d  = '0;
                    keep_d  = '0;
                    cnt_d   = '0;
                    if (accept) begin
                        data_d[WIDTH-1:0] = fifo_data_i;
                        keep_d[0]         = 1'b1;
                        cnt_d             = CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign out_vld_o  = (state_q == HOLD);
    assign out_data_o = data_q;
    assign out_keep_o = keep_q;

endmodule

// File: tb/tb_fifo_packer.sv
// Directed bench for fifo_packer: a queue models the fifo, a scoreboard holds expected beats.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
module tb_fifo_packer;

    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_read_o;
    logic        fifo_vld_i;
    logic [7:0]  fifo_data_i;
    logic        fifo_empty_i;
    logic        flush_i;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_keep_o;

    logic [7:0]  fq[$];
    beat_t       sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_beats  = 0;
    int          nb;
    logic        acc;

    fifo_packer #(
        .WIDTH   (WIDTH),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_read_o  (fifo_read_o),
        .fifo_vld_i   (fifo_vld_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .flush_i      (flush_i),
        .out_vld_o    (out_vld_o),
        .out_rdy_i    (out_rdy_i),
        .out_data_o   (out_data_o),
        .out_keep_o   (out_keep_o)
    );

    always #5 clk = ~clk;

    // The fifo's out_vld is its read request gated by not-empty.
    assign fifo_vld_i = fifo_read_o & ~fifo_empty_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    // One clock: starts and ends on a falling edge; scores a handshake seen before the rising edge.
    task automatic cyc();
        beat_t e;
        refresh();
        #1;
        if (out_vld_o === 1'b1 && out_rdy_i === 1'b1) begin
            n_beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat_sb_size", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("beat_data", 64'(out_data_o), 64'(e.d));
                check("beat_keep", 64'(out_keep_o), 64'(e.k));
            end
        end
        acc = fifo_vld_i;
        if (acc) n_acc++;
        @(negedge clk);
        if (acc) fq.delete(0);
        refresh();
    endtask

    initial begin
        reset        = 1'b1;
        flush_i      = 1'b0;
        out_rdy_i    = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 8'h00;
        @(negedge clk);

        // Reset state, with a preloaded fifo that must not be read.
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        cyc();
        cyc();
        check("rst_vld", 64'(out_vld_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        check("rst_keep", 64'(out_keep_o), 64'd0);
        check("rst_read_forced_low", 64'(fifo_read_o), 64'd0);

        // Single full beat and its latency.
        sb.push_back('{d: 32'h44332211, k: 4'hF});
        reset     = 1'b0;
        out_rdy_i = 1'b1;
        cyc();
        cyc();
        cyc();
        check("t1_not_vld_before_4th", 64'(out_vld_o), 64'd0);
        cyc();
        check("t1_vld_after_4th", 64'(out_vld_o), 64'd1);
        check("t1_accepts", 64'(n_acc), 64'd4);
        cyc();
        check("t1_beats", 64'(n_beats), 64'd1);
        check("t1_idle_after_hs", 64'(out_vld_o), 64'd0);

        // Back-to-back beats at one word per cycle.
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        sb.push_back('{d: 32'h04030201, k: 4'hF});
        sb.push_back('{d: 32'h08070605, k: 4'hF});
        n_acc = 0;
        repeat (8) cyc();
        check("t2_no_read_bubble", 64'(n_acc), 64'd8);
        check("t2_first_beat_done", 64'(n_beats), 64'd2);
        check("t2_second_beat_vld", 64'(out_vld_o), 64'd1);
        cyc();
        check("t2_second_beat_done", 64'(n_beats), 64'd3);

        // Backpressure: beat held, fifo not read, then one handshake that also refills lane 0.
        out_rdy_i = 1'b0;
        fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        sb.push_back('{d: 32'hA4A3A2A1, k: 4'hF});
        repeat (4) cyc();
        check("t3_vld", 64'(out_vld_o), 64'd1);
        fq.push_back(8'hB1);
        fq.push_back(8'hB2);
        sb.push_back('{d: 32'h0000B2B1, k: 4'h3});
        repeat (5) begin
            cyc();
            check("t3_hold_vld", 64'(out_vld_o), 64'd1);
            check("t3_hold_data", 64'(out_data_o), 64'hA4A3A2A1);
            check("t3_no_read", 64'(fifo_read_o), 64'd0);
        end
        nb        = n_beats;
        out_rdy_i = 1'b1;
        cyc();
        check("t3_single_hs", 64'(n_beats), 64'(nb + 1));
        check("t3_refill_keep", 64'(out_keep_o), 64'h1);
        check("t3_refill_data", 64'(out_data_o), 64'h000000B1);
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("t3_flush_keep", 64'(out_keep_o), 64'h3);
        cyc();

        // Partial flush, empty flush ignored, flush counting a same-cycle word.
        fq = '{8'hAA, 8'hBB};
        sb.push_back('{d: 32'h0000BBAA, k: 4'h3});
        cyc();
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("t4_flush_vld", 64'(out_vld_o), 64'd1);
        check("t4_flush_data", 64'(out_data_o), 64'h0000BBAA);
        cyc();
        nb      = n_beats;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        cyc();
        cyc();
        check("t4_empty_flush_vld", 64'(out_vld_o), 64'd0);
        check("t4_empty_flush_beats", 64'(n_beats), 64'(nb));
        fq = '{8'hCC};
        sb.push_back('{d: 32'h000000CC, k: 4'h1});
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("t4_flush_with_word_vld", 64'(out_vld_o), 64'd1);
        cyc();

        // Idle timeout (or its absence) after a single word.
        fq = '{8'h5A};
        sb.push_back('{d: 32'h0000005A, k: 4'h1});
        cyc();
`ifdef FIFO_PACKER_TIMEOUT_EN
        repeat (TIMEOUT - 1) cyc();
        check("t5_no_early_timeout", 64'(out_vld_o), 64'd0);
        cyc();
        check("t5_timeout_flush", 64'(out_vld_o), 64'd1);
        cyc();
`else
        repeat (100) cyc();
        check("t5_no_timeout_vld", 64'(out_vld_o), 64'd0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("t5_manual_flush_vld", 64'(out_vld_o), 64'd1);
        cyc();
`endif

        // Reset while holding a three-lane partial beat, then a clean full beat.
        out_rdy_i = 1'b0;
        fq = '{8'hC1, 8'hC2, 8'hC3};
        repeat (3) cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("t6_partial_keep", 64'(out_keep_o), 64'h7);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t6_rst_vld", 64'(out_vld_o), 64'd0);
        check("t6_rst_keep", 64'(out_keep_o), 64'd0);
        check("t6_rst_data", 64'(out_data_o), 64'd0);
        out_rdy_i = 1'b1;
        fq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        sb.push_back('{d: 32'hD4D3D2D1, k: 4'hF});
        repeat (4) cyc();
        check("t6_full_vld", 64'(out_vld_o), 64'd1);
        cyc();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
